// File: rtl/hello_pkg.sv
// hello_pkg: shared state type, message constants and defaults for the HELLO transmitter
package hello_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int MSG_LEN = 5;
  localparam int DEF_CLK_DIV = 4;
  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_O = 8'h4F;
  function automatic logic [7:0] msg_byte(input logic [2:0] i);
    return i == 3'd0 ? CH_H : i == 3'd1 ? CH_E : i == 3'd4 ? CH_O : CH_L;
  endfunction
endpackage

// File: rtl/hello_tx_byte.sv
// hello_tx_byte: one-byte 8N1 serializer, chains straight into the next byte when start is seen at stop end
module hello_tx_byte import hello_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       idle,
  output logic       done
);
  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
  state_t      state;
  logic [15:0] div;
  logic [2:0]  bit_idx;
  logic [7:0]  sh;
  logic        bit_end;
  assign bit_end = div == DIV_MAX;
  assign idle = state == IDLE;
  assign done = state == STOP && bit_end;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      div <= '0;
      bit_idx <= '0;
      sh <= '0;
    end else begin
      div <= state == IDLE || bit_end ? '0 : div + 16'd1;
      case (state)
        IDLE: if (start) begin
          state <= START;
          tx <= 1'b0;
          sh <= data;
        end
        START: if (bit_end) begin
          state <= DATA;
          tx <= sh[0];
          sh <= sh >> 1;
        end
        DATA: if (bit_end) begin
          state <= bit_idx == 3'd7 ? STOP : DATA;
          tx <= bit_idx == 3'd7 ? 1'b1 : sh[0];
          sh <= sh >> 1;
          bit_idx <= bit_idx + 3'd1;
        end
        STOP: if (bit_end) begin
          state <= start ? START : IDLE;
          tx <= !start;
          sh <= data;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/hello.sv
// hello: sends "HELLO" as 8N1 serial on B for each rising edge of A seen while idle
module hello import hello_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  output logic B
);
  logic       a_q;
  logic       idle;
  logic       done;
  logic       trigger;
  logic       more;
  logic [2:0] byte_idx;
  assign trigger = idle && A && !a_q;
  assign more = done && byte_idx != 3'(MSG_LEN - 1);
  always_ff @(posedge clk) begin
    a_q <= !rst && A;
    byte_idx <= rst || trigger || (done && !more) ? '0 : more ? byte_idx + 3'd1 : byte_idx;
  end
  hello_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk(clk),
    .rst(rst),
    .start(trigger || more),
    .data(msg_byte(trigger ? 3'd0 : byte_idx + 3'd1)),
    .tx(B),
    .idle(idle),
    .done(done)
  );
endmodule

// File: tb/tb_hello.sv
// tb_hello: directed checks of the HELLO transmitter at CLK_DIV=4
module tb_hello;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic A = 1'b0;
  logic B;
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] msg [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  logic w [200];
  hello #(.CLK_DIV(4)) dut (.clk(clk), .rst(rst), .A(A), .B(B));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic exp_bit(input int i);
    int pos = (i % 40) / 4;
    return pos == 0 ? 1'b0 : pos == 9 ? 1'b1 : msg[i / 40][pos - 1];
  endfunction
  task automatic watch_idle(input string tag, input int n);
    int lows = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      lows += B === 1'b1 ? 0 : 1;
    end
    check(tag, lows, 0);
  endtask
  task automatic capture(input string tag, input int mode);
    int bad = 0;
    logic [7:0] got;
    for (int i = 0; i < 200; i++) begin
      w[i] = B;
      bad += w[i] !== exp_bit(i) ? 1 : 0;
      A = mode == 1 || (mode == 2 && i % 60 == 30) || (mode == 3 && i == 199);
      tick();
    end
    check({tag, " wave"}, bad, 0);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 8; j++) got[j] = w[k * 40 + 4 * (j + 1) + 2];
      check($sformatf("%s byte%0d", tag, k), got, msg[k]);
    end
    check({tag, " end high"}, B, 1);
  endtask
  initial begin
    rst = 1'b1;
    A = 1'b0;
    tick();
    tick();
    check("reset B", B, 1);
    rst = 1'b0;
    watch_idle("idle after reset", 20);
    A = 1'b1;
    tick();
    check("start bit", B, 0);
    capture("held", 1);
    watch_idle("held no retrigger", 200);
    A = 1'b0;
    tick();
    A = 1'b1;
    tick();
    capture("pulsed", 2);
    A = 1'b1;
    tick();
    check("first idle trigger", B, 0);
    capture("first idle", 0);
    tick();
    A = 1'b1;
    tick();
    capture("last stop", 3);
    A = 1'b0;
    tick();
    check("last stop ignored", B, 1);
    A = 1'b1;
    tick();
    check("retrigger", B, 0);
    capture("retrig msg", 0);
    A = 1'b1;
    tick();
    A = 1'b0;
    repeat (90) tick();
    rst = 1'b1;
    tick();
    check("rst abort", B, 1);
    rst = 1'b0;
    watch_idle("after abort", 20);
    A = 1'b1;
    tick();
    capture("after rst", 0);
    tick();
    rst = 1'b1;
    A = 1'b1;
    tick();
    check("rst priority", B, 1);
    rst = 1'b0;
    tick();
    capture("post priority", 0);
    watch_idle("final idle", 20);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hello.md
HELLO -- requirements
Module: hello

Interface
REQ-001 Parameter CLK_DIV, default 4, clock cycles per serial bit; legal range 1 to 65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 A  input  1  trigger; a 0->1 transition requests transmission of the message.
REQ-005 B  output  1  registered serial output; idle high, 8N1 framing, LSB first.

Function
REQ-006 The block SHALL transmit the fixed 5-byte ASCII message "HELLO" (0x48 0x45 0x4C 0x4C 0x4F) on B, in that order.
REQ-007 A SHALL be sampled into register a_q each cycle; a trigger SHALL be A=1 with a_q=0 while the block is in IDLE.
REQ-008 On the trigger edge, the state SHALL move IDLE->START and B SHALL be 0 from that edge, so the start bit is visible one cycle after A is sampled high.
REQ-009 Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with each bit held for exactly CLK_DIV cycles.
REQ-010 States SHALL be IDLE, START, DATA, STOP; START->DATA, DATA->STOP after bit 7, STOP->START for the next byte with no idle gap, and STOP->IDLE after byte 4.
REQ-011 One full message SHALL last exactly 50*CLK_DIV cycles, after which B=1 and the state is IDLE.
REQ-012 A edges or levels during START, DATA or STOP SHALL be ignored and SHALL NOT be queued.
REQ-013 A held high through and beyond the end of a message SHALL NOT retrigger; A must return to 0 and rise again.
REQ-014 An A rise sampled in the final stop-bit cycle SHALL be ignored; an A rise sampled in the first IDLE cycle SHALL start a new message.
REQ-015 Internal counters SHALL be: a bit-time divider (0..CLK_DIV-1), a bit index (0..7) and a byte index (0..4); none shall wrap beyond its range.

Reset
REQ-016 While rst=1, the block SHALL hold state=IDLE, B=1, a_q=0, and all counters at 0.
REQ-017 Reset asserted mid-message SHALL abort the message, with B=1 from the next edge; after reset, the next trigger restarts at byte 0 ('H').
REQ-018 rst SHALL take priority over a simultaneous trigger.

Structure
REQ-019 Package hello_pkg SHALL hold the state enum, the message byte constants, MSG_LEN=5 and the default CLK_DIV.
REQ-020 Sub-module hello_tx_byte (one-byte 8N1 serializer with divider, start input, done output) SHALL be instantiated by hello; hello SHALL own edge detection and byte sequencing.

Verification (CLK_DIV=4)
REQ-021 rst=1 for 2 cycles, A=0 -> B=1 and no activity for 20 cycles after release.
REQ-022 A 0->1 -> B=0 for 4 cycles, then data bits 0,0,0,1,0,0,1,0 (0x48) for 4 cycles each, then 1 for 4 cycles, then the start bit of 0x45 immediately follows.
REQ-023 Single trigger, decode B -> bytes 48 45 4C 4C 4F; B returns high exactly 200 cycles after the start bit begins.
REQ-024 A pulsed 3 times during a message, and separately A held high for 400 cycles -> exactly one message each case.
REQ-025 rst pulsed during byte 2 -> B=1 next cycle; a new A rise -> message restarts with 0x48.
REQ-026 A rise sampled in the last stop cycle -> ignored; A falls and rises one cycle into IDLE -> a new message begins the next cycle.
